// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch stage: PC, imem req/ack handshake, IR and decoded field slices.
// Optional build macro FETCH_TIMEOUT_EN adds an imem_ack timeout that parks the unit in FAULT.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  typedef enum logic [1:0] {
    START = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] pc_q;
  logic [31:0] ir;
  logic        req_q;
  logic        valid_q;
  logic [31:0] redirect_target;

  // Low address bits of a redirect are dropped so every fetch stays word aligned.
  assign redirect_target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             fault_q;

  // NOTE: all state lives in one clocked block with non-blocking assignments,
  // so every register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= START;
      fetch_pc <= RESET_PC;
      pc_q     <= RESET_PC;
      ir       <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      tmo_cnt  <= '0;
    end else if (redirect && state != FAULT) begin
      // A same-cycle ack is dropped: IR and pc keep their old contents.
      fetch_pc <= redirect_target;
      state    <= REQ;
      req_q    <= 1'b1;
      valid_q  <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        START: begin
          state   <= REQ;
          req_q   <= 1'b1;
          tmo_cnt <= '0;
        end
        REQ: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            pc_q     <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= VALID;
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
            tmo_cnt  <= '0;
          end else if (tmo_cnt == CNT_LAST) begin
            state   <= FAULT;
            req_q   <= 1'b0;
            fault_q <= 1'b1;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        VALID: begin
          if (instr_ready) begin
            state   <= REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            tmo_cnt <= '0;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: state <= START;
      endcase
    end
  end

  assign fault = fault_q;
`else
  // NOTE: all state lives in one clocked block with non-blocking assignments,
  // so every register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= START;
      fetch_pc <= RESET_PC;
      pc_q     <= RESET_PC;
      ir       <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else if (redirect && state != FAULT) begin
      // A same-cycle ack is dropped: IR and pc keep their old contents.
      fetch_pc <= redirect_target;
      state    <= REQ;
      req_q    <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        START: begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            pc_q     <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= VALID;
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
          end
        end
        VALID: begin
          if (instr_ready) begin
            state   <= REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: state <= START;
      endcase
    end
  end

  // Without the timeout the limit has no consumer; FAULT is never entered.
  wire unused_timeout = |TIMEOUT_CYCLES;
  assign fault = 1'b0;
`endif

  wire unused_redirect_bits = ^redirect_pc[1:0];

  assign imem_req    = req_q;
  assign imem_addr   = fetch_pc;
  assign instr_valid = valid_q;
  assign instr       = ir;
  assign opcode      = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign funct       = ir[5:0];
  assign imm16       = ir[15:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: two instances (RESET_PC 0x0040_0000 and 0xFFFF_FFFC).
// Honours FETCH_TIMEOUT_EN to pick the expected timeout behaviour.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A
  logic        a_reset, a_ack, a_redirect, a_ready;
  logic [31:0] a_rdata, a_redirect_pc;
  logic        a_req, a_valid, a_fault;
  logic [31:0] a_addr, a_instr, a_pc, a_pc_plus4;
  logic [5:0]  a_opcode, a_funct;
  logic [4:0]  a_rs, a_rt, a_rd;
  logic [15:0] a_imm16;

  // Instance B
  logic        b_reset, b_ack, b_redirect, b_ready;
  logic [31:0] b_rdata, b_redirect_pc;
  logic        b_req, b_valid, b_fault;
  logic [31:0] b_addr, b_instr, b_pc, b_pc_plus4;
  logic [5:0]  b_opcode, b_funct;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [15:0] b_imm16;

  instr_fetch_unit #(.RESET_PC(32'h0040_0000), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .reset(a_reset), .imem_req(a_req), .imem_addr(a_addr),
    .imem_ack(a_ack), .imem_rdata(a_rdata), .redirect(a_redirect),
    .redirect_pc(a_redirect_pc), .instr_ready(a_ready), .instr_valid(a_valid),
    .instr(a_instr), .opcode(a_opcode), .rs(a_rs), .rt(a_rt), .rd(a_rd),
    .funct(a_funct), .imm16(a_imm16), .pc(a_pc), .pc_plus4(a_pc_plus4),
    .fault(a_fault)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset(b_reset), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(b_ack), .imem_rdata(b_rdata), .redirect(b_redirect),
    .redirect_pc(b_redirect_pc), .instr_ready(b_ready), .instr_valid(b_valid),
    .instr(b_instr), .opcode(b_opcode), .rs(b_rs), .rt(b_rt), .rd(b_rd),
    .funct(b_funct), .imm16(b_imm16), .pc(b_pc), .pc_plus4(b_pc_plus4),
    .fault(b_fault)
  );

  // Advance one clock; outputs are read 1 time unit after the edge and
  // inputs written here are seen at the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; a_ack = 1'b0; a_rdata = '0; a_redirect = 1'b0;
    a_redirect_pc = '0; a_ready = 1'b0;
    b_reset = 1'b1; b_ack = 1'b0; b_rdata = '0; b_redirect = 1'b0;
    b_redirect_pc = '0; b_ready = 1'b0;
    step(); step();
    checks++; if (a_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", a_req); end
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_valid); end
    checks++; if (a_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", a_fault); end
    checks++; if (a_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=00000000", a_instr); end
    checks++; if (a_pc !== 32'h0040_0000) begin failures++; $display("FAIL reset_pc got=%h exp=00400000", a_pc); end
    checks++; if (a_addr !== 32'h0040_0000) begin failures++; $display("FAIL reset_addr got=%h exp=00400000", a_addr); end
    a_reset = 1'b0;
    step();  // START -> REQ
  endtask

  task automatic test_first_fetch();
    checks++; if (a_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", a_req); end
    checks++; if (a_addr !== 32'h0040_0000) begin failures++; $display("FAIL first_addr got=%h exp=00400000", a_addr); end
    a_ack = 1'b1; a_rdata = 32'h3421_ABCD;
    step();
    a_ack = 1'b0;
    checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", a_valid); end
    checks++; if (a_req !== 1'b0) begin failures++; $display("FAIL first_req_drop got=%b exp=0", a_req); end
    checks++; if (a_opcode !== 6'h0D) begin failures++; $display("FAIL first_opcode got=%h exp=0d", a_opcode); end
    checks++; if (a_rs !== 5'd1) begin failures++; $display("FAIL first_rs got=%0d exp=1", a_rs); end
    checks++; if (a_rt !== 5'd1) begin failures++; $display("FAIL first_rt got=%0d exp=1", a_rt); end
    checks++; if (a_imm16 !== 16'hABCD) begin failures++; $display("FAIL first_imm16 got=%h exp=abcd", a_imm16); end
    checks++; if (a_pc !== 32'h0040_0000) begin failures++; $display("FAIL first_pc got=%h exp=00400000", a_pc); end
    checks++; if (a_pc_plus4 !== 32'h0040_0004) begin failures++; $display("FAIL first_pc_plus4 got=%h exp=00400004", a_pc_plus4); end
  endtask

  task automatic test_wait_and_stall();
    a_ready = 1'b1;
    step();  // consumed -> REQ
    a_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_req !== 1'b1 || a_addr !== 32'h0040_0004) begin
        failures++; $display("FAIL wait_req[%0d] got req=%b addr=%h exp req=1 addr=00400004", i, a_req, a_addr);
      end
      if (i < 3) step();
    end
    a_ack = 1'b1; a_rdata = 32'h8C49_0008;  // lw $9, 8($2)
    step();
    a_ack = 1'b1; a_rdata = 32'hDEAD_BEEF;  // ack outside REQ must be ignored
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_valid !== 1'b1 || a_req !== 1'b0 || a_instr !== 32'h8C49_0008 || a_pc !== 32'h0040_0004) begin
        failures++; $display("FAIL stall_hold[%0d] got valid=%b req=%b instr=%h pc=%h exp 1 0 8c490008 00400004", i, a_valid, a_req, a_instr, a_pc);
      end
      step();
    end
    checks++; if (a_opcode !== 6'h23 || a_rs !== 5'd2 || a_rt !== 5'd9 || a_imm16 !== 16'h0008) begin
      failures++; $display("FAIL stall_fields got op=%h rs=%0d rt=%0d imm=%h exp 23 2 9 0008", a_opcode, a_rs, a_rt, a_imm16);
    end
    a_ack = 1'b0; a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    checks++; if (a_req !== 1'b1 || a_addr !== 32'h0040_0008) begin
      failures++; $display("FAIL after_ready got req=%b addr=%h exp req=1 addr=00400008", a_req, a_addr);
    end
  endtask

  task automatic test_redirect_with_ack();
    a_ack = 1'b1; a_rdata = 32'hFFFF_FFFF; a_redirect = 1'b1; a_redirect_pc = 32'h0000_1003;
    step();
    a_redirect = 1'b0; a_ack = 1'b0;
    checks++; if (a_valid !== 1'b0 || a_req !== 1'b1 || a_addr !== 32'h0000_1000) begin
      failures++; $display("FAIL redir_ack got valid=%b req=%b addr=%h exp 0 1 00001000", a_valid, a_req, a_addr);
    end
    checks++; if (a_instr !== 32'h8C49_0008 || a_pc !== 32'h0040_0004) begin
      failures++; $display("FAIL redir_discard got instr=%h pc=%h exp 8c490008 00400004", a_instr, a_pc);
    end
    a_ack = 1'b1; a_rdata = 32'h012A_4020;  // add $8, $9, $10
    step();
    a_ack = 1'b0;
    checks++; if (a_valid !== 1'b1 || a_pc !== 32'h0000_1000 || a_rd !== 5'd8 || a_funct !== 6'h20 || a_rt !== 5'd10) begin
      failures++; $display("FAIL redir_fetch got valid=%b pc=%h rd=%0d funct=%h rt=%0d exp 1 00001000 8 20 10", a_valid, a_pc, a_rd, a_funct, a_rt);
    end
  endtask

  task automatic test_redirect_in_valid();
    a_redirect = 1'b1; a_redirect_pc = 32'h0000_2000; a_ready = 1'b1;
    step();
    a_redirect = 1'b0; a_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (a_req !== 1'b1 || a_valid !== 1'b0 || a_addr !== 32'h0000_2000) begin
        failures++; $display("FAIL redir_valid_req[%0d] got req=%b valid=%b addr=%h exp 1 0 00002000", i, a_req, a_valid, a_addr);
      end
      if (i < 2) step();
    end
    a_ack = 1'b1; a_rdata = 32'h0800_0400;
    step();
    a_ack = 1'b0;
    checks++; if (a_valid !== 1'b1 || a_pc !== 32'h0000_2000 || a_opcode !== 6'h02) begin
      failures++; $display("FAIL redir_valid_word got valid=%b pc=%h op=%h exp 1 00002000 02", a_valid, a_pc, a_opcode);
    end
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    checks++; if (a_req !== 1'b1 || a_addr !== 32'h0000_2004) begin
      failures++; $display("FAIL redir_valid_next got req=%b addr=%h exp 1 00002004", a_req, a_addr);
    end
  endtask

  task automatic test_timeout();
    // The unit is in its first REQ cycle at 0x2004 with no ack.
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step();
    checks++; if (a_req !== 1'b1 || a_fault !== 1'b0) begin
      failures++; $display("FAIL timeout_pre got req=%b fault=%b exp 1 0", a_req, a_fault);
    end
    step();
    checks++; if (a_fault !== 1'b1 || a_req !== 1'b0 || a_valid !== 1'b0) begin
      failures++; $display("FAIL timeout_fault got fault=%b req=%b valid=%b exp 1 0 0", a_fault, a_req, a_valid);
    end
    a_ack = 1'b1; a_redirect = 1'b1; a_redirect_pc = 32'h0000_3000;
    step(); step();
    a_ack = 1'b0; a_redirect = 1'b0;
    checks++; if (a_fault !== 1'b1 || a_req !== 1'b0) begin
      failures++; $display("FAIL timeout_sticky got fault=%b req=%b exp 1 0", a_fault, a_req);
    end
`else
    for (int i = 0; i < 20; i++) step();
    checks++; if (a_req !== 1'b1 || a_fault !== 1'b0 || a_addr !== 32'h0000_2004) begin
      failures++; $display("FAIL no_timeout got req=%b fault=%b addr=%h exp 1 0 00002004", a_req, a_fault, a_addr);
    end
`endif
    a_reset = 1'b1;
    step();
    a_reset = 1'b0;
    checks++; if (a_fault !== 1'b0 || a_req !== 1'b0 || a_addr !== 32'h0040_0000) begin
      failures++; $display("FAIL timeout_reset got fault=%b req=%b addr=%h exp 0 0 00400000", a_fault, a_req, a_addr);
    end
    step();
    checks++; if (a_req !== 1'b1 || a_addr !== 32'h0040_0000) begin
      failures++; $display("FAIL timeout_restart got req=%b addr=%h exp 1 00400000", a_req, a_addr);
    end
  endtask

  task automatic test_wrap();
    b_reset = 1'b0;
    step();
    checks++; if (b_req !== 1'b1 || b_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_first_req got req=%b addr=%h exp 1 fffffffc", b_req, b_addr);
    end
    b_ack = 1'b1; b_rdata = 32'h0000_0000;
    step();
    b_ack = 1'b0;
    checks++; if (b_valid !== 1'b1 || b_pc !== 32'hFFFF_FFFC || b_pc_plus4 !== 32'h0000_0000) begin
      failures++; $display("FAIL wrap_first got valid=%b pc=%h pc_plus4=%h exp 1 fffffffc 00000000", b_valid, b_pc, b_pc_plus4);
    end
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    checks++; if (b_req !== 1'b1 || b_addr !== 32'h0000_0000) begin
      failures++; $display("FAIL wrap_second_req got req=%b addr=%h exp 1 00000000", b_req, b_addr);
    end
    b_ack = 1'b1; b_rdata = 32'h2008_0005;
    step();
    b_ack = 1'b0;
    checks++; if (b_valid !== 1'b1 || b_pc !== 32'h0000_0000 || b_pc_plus4 !== 32'h0000_0004 || b_imm16 !== 16'h0005) begin
      failures++; $display("FAIL wrap_second got valid=%b pc=%h pc_plus4=%h imm=%h exp 1 00000000 00000004 0005", b_valid, b_pc, b_pc_plus4, b_imm16);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_wait_and_stall();
    test_redirect_with_ack();
    test_redirect_in_valid();
    test_timeout();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
